dlx_sequencer: RTL

Multi-cycle control sequencer for the DLX core. It steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK. It generates the one-cycle `ID` strobe that makes the decoder capture `i_data_read`, and handshakes with instruction and data memory. It also issues the register-file write enable and PC update at retirement. It sits between the memories and the decoder/ALU/register file, and uses the decoder's registered outputs to choose the path each instruction takes.

---
 rtl/dlx_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/dlx_sequencer.sv
// ============================================================================
// Module   : dlx_sequencer
// Function : Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control FSM
//            for the DLX core, with a memory-ack timeout and a sticky bus error.
//            Optional performance counters: define DLX_SEQ_PERF_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dlx_sequencer #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       i_ack,
    input  logic       d_ack,
    input  logic       d_load_enable,
    input  logic       d_write_enable,
    input  logic [4:0] Rd,
    output logic       i_req,
    output logic       ID,
    output logic       EX,
    output logic       d_req,
    output logic       d_we,
    output logic       reg_we,
    output logic       pc_en,
    output logic       busy,
    output logic       bus_error
`ifdef DLX_SEQ_PERF_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
`endif
);

    localparam int               CNT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic             C_TO_EN   = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_ERROR     = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             w_timeout;
    logic             i_req_q, id_q, ex_q, d_req_q, pc_en_q, busy_q, bus_error_q;

    assign w_timeout = C_TO_EN && (wait_q == C_TIMEOUT);

    // The ack is tested before the timeout so a late ack on the last allowed cycle still wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (run) state_d = S_FETCH;
            S_FETCH: begin
                if (i_ack)          state_d = S_DECODE;
                else if (w_timeout) state_d = S_ERROR;
            end
            S_DECODE:    state_d = S_EXECUTE;
            S_EXECUTE:   state_d = (d_load_enable || d_write_enable) ? S_MEMORY : S_WRITEBACK;
            S_MEMORY: begin
                if (d_ack)          state_d = S_WRITEBACK;
                else if (w_timeout) state_d = S_ERROR;
            end
            S_WRITEBACK: state_d = run ? S_FETCH : S_IDLE;
            S_ERROR:     state_d = S_ERROR;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wait_d = '0;
        if ((state_d == S_FETCH || state_d == S_MEMORY) && (state_d == state_q)) begin
            wait_d = (wait_q == {CNT_W{1'b1}}) ? wait_q : wait_q + CNT_W'(1);
        end
    end

    // Strobes are decoded from the next state so each one is a clean register output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            i_req_q     <= 1'b0;
            id_q        <= 1'b0;
            ex_q        <= 1'b0;
            d_req_q     <= 1'b0;
            pc_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            i_req_q     <= (state_d == S_FETCH);
            id_q        <= (state_d == S_DECODE);
            ex_q        <= (state_d == S_EXECUTE);
            d_req_q     <= (state_d == S_MEMORY);
            pc_en_q     <= (state_d == S_WRITEBACK);
            busy_q      <= (state_d != S_IDLE) && (state_d != S_ERROR);
            bus_error_q <= (state_d == S_ERROR);
        end
    end

    assign i_req     = i_req_q;
    assign ID        = id_q;
    assign EX        = ex_q;
    assign d_req     = d_req_q;
    assign pc_en     = pc_en_q;
    assign busy      = busy_q;
    assign bus_error = bus_error_q;
    assign d_we      = d_req_q & d_write_enable;
    assign reg_we    = pc_en_q & (Rd != 5'd0) & ~d_write_enable;

`ifdef DLX_SEQ_PERF_EN
    logic [31:0] cycle_count_q, instr_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count_q <= '0;
            instr_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_q + {31'd0, busy_q};
            instr_count_q <= instr_count_q + {31'd0, pc_en_q};
        end
    end

    assign cycle_count = cycle_count_q;
    assign instr_count = instr_count_q;
`endif

endmodule

`default_nettype wire
